mont_ladder_exp: RTL

- Parametrised Montgomery-ladder modular exponentiation controller: result = x^e mod m, for a configurable operand WIDTH and exponent length.
- Drives two external Montgomery multiplier channels through start/done handshakes. Channel 0 is a general multiplier; channel 1 is a squarer.
- Sits between the RSA top-level control and the multiplier datapath. Adds start/busy handshake, input latching, e_len clamping and zero-exponent handling.

---
 rtl/mont_ladder_exp_if.sv | 26 ++
 rtl/mont_ladder_exp.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mont_ladder_exp_if.sv
// Multiplier-channel bus between the ladder controller (master) and the two
// Montgomery multiplier channels (slave): channel 0 general, channel 1 squarer.
interface mont_ladder_exp_if #(
    parameter int unsigned WIDTH = 1024
);
    logic [WIDTH-1:0] mm_m;
    logic             mm0_start;
    logic [WIDTH-1:0] mm0_a;
    logic [WIDTH-1:0] mm0_b;
    logic [WIDTH-1:0] mm0_res;
    logic             mm0_done;
    logic             mm1_start;
    logic [WIDTH-1:0] mm1_a;
    logic [WIDTH-1:0] mm1_res;
    logic             mm1_done;

    modport master (
        output mm_m, mm0_start, mm0_a, mm0_b, mm1_start, mm1_a,
        input  mm0_res, mm0_done, mm1_res, mm1_done
    );

    modport slave (
        input  mm_m, mm0_start, mm0_a, mm0_b, mm1_start, mm1_a,
        output mm0_res, mm0_done, mm1_res, mm1_done
    );
endinterface

// File: rtl/mont_ladder_exp.sv
// Montgomery-ladder modular exponentiation controller: result = x^e mod m.
// Optional LZ_SKIP_EN: scan away leading zero exponent bits without multiplies.
module mont_ladder_exp #(
    parameter int unsigned WIDTH = 1024,
    parameter int unsigned LEN_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    output logic              busy_o,
    input  logic [WIDTH-1:0]  x_i,
    input  logic [WIDTH-1:0]  m_i,
    input  logic [WIDTH-1:0]  e_i,
    input  logic [WIDTH-1:0]  r_i,
    input  logic [WIDTH-1:0]  r2_i,
    input  logic [LEN_W-1:0]  e_len_i,
    output logic [WIDTH-1:0]  result_o,
    output logic              done_o,
    mont_ladder_exp_if.master mm
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [3:0] {
        StIdle, StToMontWait, StScan, StRoundIssue, StRoundWait,
        StFromMontIssue, StFromMontWait, StDone
    } state_e;

    state_e           state_q;
    logic             busy_q, done_q, bit_q, f0_q, f1_q;
    logic             mm0_start_q, mm1_start_q;
    logic [WIDTH-1:0] result_q, m_q, a_q, xx_q, es_q;
    logic [WIDTH-1:0] mm0_a_q, mm0_b_q, mm1_a_q;
    logic [CntW-1:0]  len_q, cnt_q, cnt_inc, len_in;

    always_comb begin
        len_in = CntW'(WIDTH);
        if (e_len_i <= LEN_W'(WIDTH)) len_in = CntW'(e_len_i);
    end

    assign cnt_inc = cnt_q + CntW'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bit_q       <= 1'b0;
            f0_q        <= 1'b0;
            f1_q        <= 1'b0;
            mm0_start_q <= 1'b0;
            mm1_start_q <= 1'b0;
            result_q    <= '0;
            m_q         <= '0;
            a_q         <= '0;
            xx_q        <= '0;
            es_q        <= '0;
            mm0_a_q     <= '0;
            mm0_b_q     <= '0;
            mm1_a_q     <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
        end else begin
            mm0_start_q <= 1'b0;
            mm1_start_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        // Acceptance doubles as the TOMONT issue: mm0 = x * R^2.
                        m_q         <= m_i;
                        len_q       <= len_in;
                        es_q        <= e_i << (CntW'(WIDTH) - len_in);
                        cnt_q       <= '0;
                        a_q         <= r_i;
                        mm0_a_q     <= x_i;
                        mm0_b_q     <= r2_i;
                        mm0_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= StToMontWait;
                    end
                end
                StToMontWait: begin
                    if (mm.mm0_done) begin
                        xx_q <= mm.mm0_res;
                        if (len_q == '0) state_q <= StFromMontIssue;
`ifdef LZ_SKIP_EN
                        else if (!es_q[WIDTH-1]) state_q <= StScan;
`endif
                        else state_q <= StRoundIssue;
                    end
                end
`ifdef LZ_SKIP_EN
                StScan: begin
                    es_q  <= es_q << 1;
                    cnt_q <= cnt_inc;
                    if (cnt_inc == len_q) state_q <= StFromMontIssue;
                    else if (es_q[WIDTH-2]) state_q <= StRoundIssue;
                end
`endif
                StRoundIssue: begin
                    bit_q       <= es_q[WIDTH-1];
                    mm0_a_q     <= a_q;
                    mm0_b_q     <= xx_q;
                    mm1_a_q     <= es_q[WIDTH-1] ? xx_q : a_q;
                    mm0_start_q <= 1'b1;
                    mm1_start_q <= 1'b1;
                    f0_q        <= 1'b0;
                    f1_q        <= 1'b0;
                    state_q     <= StRoundWait;
                end
                StRoundWait: begin
                    if (f0_q && f1_q) begin
                        f0_q  <= 1'b0;
                        f1_q  <= 1'b0;
                        es_q  <= es_q << 1;
                        cnt_q <= cnt_inc;
                        state_q <= (cnt_inc == len_q) ? StFromMontIssue : StRoundIssue;
                    end else begin
                        // Sticky flags let the two channels finish in any order.
                        if (mm.mm0_done && !f0_q) begin
                            f0_q <= 1'b1;
                            if (bit_q) a_q <= mm.mm0_res;
                            else       xx_q <= mm.mm0_res;
                        end
                        if (mm.mm1_done && !f1_q) begin
                            f1_q <= 1'b1;
                            if (bit_q) xx_q <= mm.mm1_res;
                            else       a_q  <= mm.mm1_res;
                        end
                    end
                end
                StFromMontIssue: begin
                    mm0_a_q     <= a_q;
                    mm0_b_q     <= WIDTH'(1);
                    mm0_start_q <= 1'b1;
                    state_q     <= StFromMontWait;
                end
                StFromMontWait: begin
                    if (mm.mm0_done) begin
                        result_q <= mm.mm0_res;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign result_o     = result_q;
    assign mm.mm_m      = m_q;
    assign mm.mm0_start = mm0_start_q;
    assign mm.mm0_a     = mm0_a_q;
    assign mm.mm0_b     = mm0_b_q;
    assign mm.mm1_start = mm1_start_q;
    assign mm.mm1_a     = mm1_a_q;
endmodule
